// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU / multiply-divide control.
// Operation codes, ALUOp classes, Funct7 groups, M-op and FSM enums.
package alu_pkg;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLL     = 4'b0111;
  localparam logic [3:0] ALU_SRL     = 4'b1000;
  localparam logic [3:0] ALU_SLT     = 4'b1001;
  localparam logic [3:0] ALU_SLTU    = 4'b1010;
  localparam logic [3:0] ALU_SRA     = 4'b1011;
  localparam logic [3:0] ALU_BGE     = 4'b1100;
  localparam logic [3:0] ALU_BGEU    = 4'b1101;
  localparam logic [3:0] ALU_BNE     = 4'b1110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU,
    MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE, BUSY, DONE
  } md_state_e;

  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_md_controller_if.sv
// ID/EX-side bundle into the ALU controller and its results back.
// master drives the instruction fields, slave is the controller.
interface alu_md_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            flush_i;
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [3:0]      Operation;
  logic            md_sel;
  logic            stall_o;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output valid_i, flush_i, ALUOp, Funct7, Funct3,
    output rs1_i, rs2_i,
    input  Operation, md_sel, stall_o, md_done, md_result
  );

  modport slave (
    input  valid_i, flush_i, ALUOp, Funct7, Funct3,
    input  rs1_i, rs2_i,
    output Operation, md_sel, stall_o, md_done, md_result
  );
endinterface

// File: rtl/alu_md_controller_md_iter_unit.sv
// Radix-2 iterative multiply / restoring divide on magnitudes.
// Outputs are the values after the current step (valid on the last one).
module md_iter_unit #(
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     step,
  input  logic                     is_div,
  input  logic [$clog2(XLEN)-1:0]  count,
  input  logic [XLEN-1:0]          a,
  input  logic [XLEN-1:0]          b,
  output logic [2*XLEN-1:0]        product,
  output logic [XLEN-1:0]          quotient,
  output logic [XLEN-1:0]          remainder
);

  logic [2*XLEN-1:0] mcand_q;
  logic [2*XLEN-1:0] prod_q;
  logic [XLEN-1:0]   mplier_q;
  logic [XLEN-1:0]   dvsr_q;
  logic [XLEN-1:0]   quo_q;
  logic [XLEN-1:0]   rem_q;
  logic [XLEN:0]     trial;
  logic [XLEN:0]     diff;

  // One shift-add and one restoring-divide step from current state
  always_comb begin
    product   = prod_q + (mplier_q[count] ? mcand_q : '0);
    trial     = {rem_q, quo_q[XLEN-1]};
    diff      = trial - {1'b0, dvsr_q};
    quotient  = {quo_q[XLEN-2:0], ~diff[XLEN]};
    remainder = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
  end

  // Load operands on start, then advance the selected datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      dvsr_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else if (start) begin
      mcand_q  <= {{XLEN{1'b0}}, a};
      prod_q   <= '0;
      mplier_q <= b;
      dvsr_q   <= b;
      quo_q    <= a;
      rem_q    <= '0;
    end else if (step) begin
      if (is_div) begin
        quo_q <= quotient;
        rem_q <= remainder;
      end else begin
        prod_q  <= product;
        mcand_q <= mcand_q << 1;
      end
    end
  end

endmodule

// File: rtl/alu_md_controller.sv
// EX-stage ALU operation decode plus RV32M sequencing FSM.
// Stalls the pipeline while the iterative mul/div unit works.
module alu_md_controller
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit MD_EN = 1'b1
) (
  input logic     clk,
  input logic     reset,
  alu_md_if.slave bus
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state;
  md_op_e            op;
  md_op_e            op_q;
  logic [CW-1:0]     count;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic              res_neg;
  logic              rem_neg;
  logic [3:0]        oper;
  logic              sel;
  logic              start;
  logic              sgn_a;
  logic              sgn_b;
  logic              a_neg;
  logic              b_neg;
  logic              by_zero;
  logic              ovf;
  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   special;
  logic [XLEN-1:0]   fixed;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  // Base-ISA operation decode; anything unlisted is ILLEGAL
  always_comb begin
    oper = ALU_ILLEGAL;
    unique case (bus.ALUOp)
      ALUOP_MEM: oper = ALU_ADD;
      ALUOP_BR: begin
        case (bus.Funct3)
          3'b000:  oper = ALU_SUB;
          3'b001:  oper = ALU_BNE;
          3'b100:  oper = ALU_SLT;
          3'b101:  oper = ALU_BGE;
          3'b110:  oper = ALU_SLTU;
          3'b111:  oper = ALU_BGEU;
          default: oper = ALU_ILLEGAL;
        endcase
      end
      ALUOP_R: begin
        if (bus.Funct7 == FUNCT7_BASE) begin
          oper = base_op(bus.Funct3);
        end else if (bus.Funct7 == FUNCT7_ALT) begin
          if (bus.Funct3 == 3'b000) oper = ALU_SUB;
          else if (bus.Funct3 == 3'b101) oper = ALU_SRA;
        end
      end
      ALUOP_I: begin
        case (bus.Funct3)
          3'b001: begin
            if (bus.Funct7 == FUNCT7_BASE) oper = ALU_SLL;
          end
          3'b101: begin
            if (bus.Funct7 == FUNCT7_BASE) oper = ALU_SRL;
            else if (bus.Funct7 == FUNCT7_ALT) oper = ALU_SRA;
          end
          default: oper = base_op(bus.Funct3);
        endcase
      end
      default: oper = ALU_ILLEGAL;
    endcase
  end

  assign sel = MD_EN && (bus.ALUOp == ALUOP_R)
             && (bus.Funct7 == FUNCT7_MULDIV);
  assign op = md_op_e'(bus.Funct3);
  assign start = (state == IDLE) && bus.valid_i
               && sel && !bus.flush_i;

  // Which operands are treated as signed for this M-op
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
    case (op)
      MD_MULH, MD_DIV, MD_REM: begin
        sgn_a = 1'b1;
        sgn_b = 1'b1;
      end
      MD_MULHSU: sgn_a = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = sgn_a & bus.rs1_i[XLEN-1];
  assign b_neg = sgn_b & bus.rs2_i[XLEN-1];
  assign a_mag = a_neg ? -bus.rs1_i : bus.rs1_i;
  assign b_mag = b_neg ? -bus.rs2_i : bus.rs2_i;
  assign by_zero = bus.Funct3[2] && (bus.rs2_i == '0);
  assign ovf = sgn_b && bus.Funct3[2]
             && (bus.rs1_i == MIN) && (bus.rs2_i == '1);
  assign special = bus.Funct3[1]
                 ? (by_zero ? bus.rs1_i : '0)
                 : (by_zero ? '1 : MIN);

  // Sign fix-up and result select on the final step's values
  always_comb begin
    prod_s = res_neg ? -product : product;
    quo_s  = res_neg ? -quotient : quotient;
    rem_s  = rem_neg ? -remainder : remainder;
    case (op_q)
      MD_MUL:                       fixed = prod_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fixed = prod_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fixed = quo_s;
      default:                      fixed = rem_s;
    endcase
  end

  md_iter_unit #(
    .XLEN(XLEN)
  ) u_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step      (state == BUSY),
    .is_div    (op_q[2]),
    .count     (count),
    .a         (a_mag),
    .b         (b_mag),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // IDLE -> BUSY (XLEN steps) or straight to DONE; DONE lasts one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      op_q     <= MD_MUL;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            count   <= '0;
            if (by_zero || ovf) begin
              result_q <= special;
              done_q   <= 1'b1;
              state    <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush_i) begin
            state <= IDLE;
          end else begin
            count <= count + 1'b1;
            if (count == LAST) begin
              result_q <= fixed;
              done_q   <= 1'b1;
              state    <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Operation = oper;
  assign bus.md_sel    = sel;
  assign bus.stall_o   = start || (state == BUSY);
  assign bus.md_done   = done_q;
  assign bus.md_result = result_q;

endmodule

// File: tb/tb_alu_md_controller.sv
// Directed bench for alu_md_controller (MD_EN=1 and MD_EN=0 builds).
// Behavioural model plus literal expectations for each M-op.
module tb_alu_md_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_md_if #(.XLEN(32)) bus0 ();
  alu_md_if #(.XLEN(32)) bus1 ();

  assign bus1.valid_i = bus0.valid_i;
  assign bus1.flush_i = bus0.flush_i;
  assign bus1.ALUOp   = bus0.ALUOp;
  assign bus1.Funct7  = bus0.Funct7;
  assign bus1.Funct3  = bus0.Funct3;
  assign bus1.rs1_i   = bus0.rs1_i;
  assign bus1.rs2_i   = bus0.rs2_i;

  alu_md_controller #(.XLEN(32), .MD_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  alu_md_controller #(.XLEN(32), .MD_EN(1'b0)) dut_nomd (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  logic [3:0] base_tbl [8] = '{4'h2, 4'h7, 4'h9, 4'hA,
                               4'h3, 4'h8, 4'h1, 4'h0};
  logic [3:0] br_tbl [8]   = '{4'h6, 4'hE, 4'hF, 4'hF,
                               4'h9, 4'hC, 4'hA, 4'hD};
  logic [6:0] f7s [4]      = '{7'h00, 7'h20, 7'h01, 7'h7F};

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] rtype(input logic [6:0] f7,
                                       input logic [2:0] f3);
    if (f7 == 7'h00) return base_tbl[f3];
    if (f7 == 7'h20 && f3 == 3'd0) return 4'h6;
    if (f7 == 7'h20 && f3 == 3'd5) return 4'hB;
    return 4'hF;
  endfunction

  function automatic logic [3:0] exp_op(input logic [1:0] aop,
                                        input logic [6:0] f7,
                                        input logic [2:0] f3);
    case (aop)
      2'd0:    return 4'h2;
      2'd1:    return br_tbl[f3];
      2'd2:    return rtype(f7, f3);
      default: return (f3 == 3'd1 || f3 == 3'd5)
                      ? rtype(f7, f3) : base_tbl[f3];
    endcase
  endfunction

  function automatic logic md_special(input logic [2:0] f3,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
    return f3[2] && (b == 32'd0 || (!f3[0]
           && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] md_res(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    p = '0;
    case (f3)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * ub;
      3'd3: p = ua * ub;
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  // Model: cycles left until the result is due (0 = free to start)
  int left = 0;
  logic [31:0] pend = '0;
  logic [31:0] held = '0;
  wire md_sel_x = (bus0.ALUOp == 2'b10) && (bus0.Funct7 == 7'h01);
  wire go = (left == 0) && bus0.valid_i && md_sel_x && !bus0.flush_i;

  always @(posedge clk) begin
    if (reset) begin
      left <= 0;
      held <= '0;
    end else begin
      if (left == 1) held <= pend;
      if (left == 0) begin
        if (go) begin
          pend <= md_res(bus0.Funct3, bus0.rs1_i, bus0.rs2_i);
          left <= md_special(bus0.Funct3, bus0.rs1_i, bus0.rs2_i)
                  ? 1 : 33;
        end
      end else if (bus0.flush_i) begin
        left <= 0;
      end else begin
        left <= left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("op", bus0.Operation,
          exp_op(bus0.ALUOp, bus0.Funct7, bus0.Funct3));
      chk("md_sel", bus0.md_sel, md_sel_x);
      chk("stall", bus0.stall_o, go || left > 1);
      chk("md_done", bus0.md_done, left == 1);
      chk("md_result", bus0.md_result, (left == 1) ? pend : held);
      chk("nomd_op", bus1.Operation,
          exp_op(bus0.ALUOp, bus0.Funct7, bus0.Funct3));
      chk("nomd_sel", bus1.md_sel, 32'd0);
      chk("nomd_stall", bus1.stall_o, 32'd0);
      chk("nomd_done", bus1.md_done, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] aop,
                       input logic [6:0] f7, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b);
    bus0.valid_i = v;
    bus0.ALUOp   = aop;
    bus0.Funct7  = f7;
    bus0.Funct3  = f3;
    bus0.rs1_i   = a;
    bus0.rs2_i   = b;
  endtask

  task automatic run_md(input string nm, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int lat);
    int n;
    int st;
    bit got;
    n = 0;
    st = 0;
    got = 1'b0;
    drive(1'b1, 2'b10, 7'h01, f3, a, b);
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus0.stall_o) st++;
      if (bus0.md_done) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      errors++;
      $display("FAIL %s: md_done missing after %0d cycles", nm, n);
    end else begin
      chk({nm, "_lat"}, n - 1, lat);
      chk({nm, "_stall"}, st, lat);
      chk(nm, bus0.md_result, want);
    end
    tick();
    bus0.valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    bus0.flush_i = 1'b0;
    drive(1'b0, 2'b00, 7'h00, 3'b000, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", bus0.md_done, 32'd0);
    chk("rst_result", bus0.md_result, 32'd0);
    chk("rst_stall", bus0.stall_o, 32'd0);
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    for (int i = 0; i < 4; i++) begin
      for (int f = 0; f < 8; f++) begin
        for (int k = 0; k < 4; k++) begin
          drive(1'b0, 2'(i), f7s[k], 3'(f), 32'(i * f), 32'(k));
          tick();
        end
      end
    end

    drive(1'b0, 2'b10, 7'h20, 3'b101, 32'd0, 32'd0);
    @(negedge clk);
    chk("sra_lit", bus0.Operation, 32'hB);
    tick();
    drive(1'b0, 2'b01, 7'h00, 3'b010, 32'd0, 32'd0);
    @(negedge clk);
    chk("br010_lit", bus0.Operation, 32'hF);
    tick();
    drive(1'b0, 2'b00, 7'h7F, 3'b110, 32'd0, 32'd0);
    @(negedge clk);
    chk("ld_lit", bus0.Operation, 32'h2);
    tick();
    drive(1'b0, 2'b11, 7'h20, 3'b001, 32'd0, 32'd0);
    @(negedge clk);
    chk("slli_bad_lit", bus0.Operation, 32'hF);
    tick();
    drive(1'b0, 2'b10, 7'h01, 3'b000, 32'd0, 32'd0);
    @(negedge clk);
    chk("mext_op_lit", bus0.Operation, 32'hF);
    chk("mext_sel_lit", bus0.md_sel, 32'd1);
    chk("nomd_op_lit", bus1.Operation, 32'hF);
    chk("nomd_sel_lit", bus1.md_sel, 32'd0);
    tick();

    run_md("mul", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33);
    run_md("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 33);
    run_md("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000,
           32'h4000_0000, 33);
    run_md("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
    run_md("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_md("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_md("divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_md("remu", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_md("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_md("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_md("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    run_md("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_md("mul2", 3'd0, 32'd6, 32'd7, 32'd42, 33);
    tick();

    drive(1'b1, 2'b10, 7'h01, 3'b000, 32'd9, 32'd9);
    repeat (10) tick();
    bus0.flush_i = 1'b1;
    bus0.valid_i = 1'b0;
    tick();
    bus0.flush_i = 1'b0;
    @(negedge clk);
    chk("flush_stall", bus0.stall_o, 32'd0);
    chk("flush_done", bus0.md_done, 32'd0);
    d = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus0.md_done) d++;
    end
    chk("flush_nodone", d, 32'd0);
    chk("flush_hold", bus0.md_result, 32'd42);
    tick();

    drive(1'b1, 2'b10, 7'h01, 3'b001, 32'd3, 32'd3);
    repeat (5) tick();
    reset = 1'b1;
    bus0.valid_i = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy_done", bus0.md_done, 32'd0);
    chk("rst_busy_result", bus0.md_result, 32'd0);
    chk("rst_busy_stall", bus0.stall_o, 32'd0);
    tick();

    run_md("post_rst", 3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
